// File: rtl/spu_ri10_pkg.sv
// Shared definitions for the SPU RI10 halfword execute path: opcodes, op enum,
// instruction field positions and the opcode decoder.
package spu_ri10_pkg;

  localparam logic [7:0] OP_ANDHI  = 8'h15;
  localparam logic [7:0] OP_ORHI   = 8'h05;
  localparam logic [7:0] OP_XORHI  = 8'h45;
  localparam logic [7:0] OP_AHI    = 8'h1D;
  localparam logic [7:0] OP_SFHI   = 8'h0D;
  localparam logic [7:0] OP_CEQHI  = 8'h7D;
  localparam logic [7:0] OP_CGTHI  = 8'h4D;
  localparam logic [7:0] OP_CLGTHI = 8'h5D;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 24;
  localparam int unsigned I10_MSB = 23;
  localparam int unsigned I10_LSB = 14;
  localparam int unsigned RA_MSB  = 13;
  localparam int unsigned RA_LSB  = 7;
  localparam int unsigned RT_MSB  = 6;
  localparam int unsigned RT_LSB  = 0;

  typedef enum logic [3:0] {
    HW_AND, HW_OR, HW_XOR, HW_ADD, HW_SUBF, HW_CEQ, HW_CGT, HW_CLGT, HW_ILL
  } hw_op_e;

  function automatic hw_op_e decode_op(input logic [7:0] opc);
    case (opc)
      OP_ANDHI:  return HW_AND;
      OP_ORHI:   return HW_OR;
      OP_XORHI:  return HW_XOR;
      OP_AHI:    return HW_ADD;
      OP_SFHI:   return HW_SUBF;
      OP_CEQHI:  return HW_CEQ;
      OP_CGTHI:  return HW_CGT;
      OP_CLGTHI: return HW_CLGT;
      default:   return HW_ILL;
    endcase
  endfunction

endpackage

// File: rtl/hw_slot_alu.sv
// One 16-bit halfword slot of the RI10 ALU; purely combinational.
module hw_slot_alu
  import spu_ri10_pkg::*;
(
  input  hw_op_e      op,
  input  logic [15:0] a,
  input  logic [15:0] t,
  output logic [15:0] y
);

  always_comb begin
    y = 16'h0000;
    case (op)
      HW_AND:  y = a & t;
      HW_OR:   y = a | t;
      HW_XOR:  y = a ^ t;
      HW_ADD:  y = a + t;
      HW_SUBF: y = t - a;
      HW_CEQ:  y = (a == t) ? 16'hFFFF : 16'h0000;
      HW_CGT:  y = ($signed(a) > $signed(t)) ? 16'hFFFF : 16'h0000;
      HW_CLGT: y = (a > t) ? 16'hFFFF : 16'h0000;
      default: y = 16'h0000;
    endcase
  end

endmodule

// File: rtl/ri10_hw_exec_pipe.sv
// Two-stage RI10 halfword execute pipe: S1 latches decoded operands, the output
// stage latches eight slot results; valid/ready with backpressure on both sides.
module ri10_hw_exec_pipe
  import spu_ri10_pkg::*;
#(
  parameter int unsigned DEPTH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [127:0]           in_ra,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             out_rt,
  output logic [127:0]           out_result,
  output logic                   out_illegal,
  output logic [DEPTH_CNT_W-1:0] retired_cnt
);

  logic           s1_valid_q;
  hw_op_e         s1_op_q;
  logic [15:0]    s1_t_q;
  logic [127:0]   s1_ra_q;
  logic [6:0]     s1_rt_q;
  logic [127:0]   alu_res;
  logic [9:0]     i10;
  logic           s2_free;
  logic           s1_adv;
  logic           accept;
  logic           unused_ra;

  // RA index is resolved upstream; only the operand value is used here.
  assign unused_ra = ^in_inst[RA_MSB:RA_LSB];
  assign i10       = in_inst[I10_MSB:I10_LSB];

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= HW_AND;
      s1_t_q     <= '0;
      s1_ra_q    <= '0;
      s1_rt_q    <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= decode_op(in_inst[OPC_MSB:OPC_LSB]);
      s1_t_q     <= {{6{i10[9]}}, i10};
      s1_ra_q    <= in_ra;
      s1_rt_q    <= in_inst[RT_MSB:RT_LSB];
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_slot
    hw_slot_alu u_alu (
      .op (s1_op_q),
      .a  (s1_ra_q[16*i +: 16]),
      .t  (s1_t_q),
      .y  (alu_res[16*i +: 16])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_rt      <= '0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid   <= 1'b1;
      out_rt      <= s1_rt_q;
      out_result  <= alu_res;
      out_illegal <= (s1_op_q == HW_ILL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Handshakes in a flush cycle still retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (out_valid && out_ready) begin
      retired_cnt <= retired_cnt + DEPTH_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ri10_hw_exec_pipe.sv
// Scoreboard bench for ri10_hw_exec_pipe: driver pushes expected results on
// accept, a negedge monitor pops and compares on each output handshake.
module tb_ri10_hw_exec_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_inst;
  logic [127:0] in_ra;
  logic         out_valid;
  logic         out_ready;
  logic [6:0]   out_rt;
  logic [127:0] out_result;
  logic         out_illegal;
  logic [15:0]  retired_cnt;

  typedef struct packed {
    logic [6:0]   rt;
    logic [127:0] res;
    logic         ill;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  logic saw_stall = 1'b0;

  localparam logic [127:0] RA1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  ri10_hw_exec_pipe #(.DEPTH_CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_ra       (in_ra),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rt      (out_rt),
    .out_result  (out_result),
    .out_illegal (out_illegal),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [9:0] i10,
                                     input logic [6:0] rt);
    return {op, i10, 7'd3, rt};
  endfunction

  // Monitor: inputs change only #1 after posedge, so negedge values are what the edge sees.
  always @(negedge clk) begin
    if (rst_n && in_valid && !in_ready) saw_stall = 1'b1;
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      hs_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got rt %0d result %h expected no output",
                 out_rt, out_result);
      end else begin
        e = sbq.pop_front();
        chk("out_rt", 128'(out_rt), 128'(e.rt));
        chk("out_result", out_result, e.res);
        chk("out_illegal", 128'(out_illegal), 128'(e.ill));
      end
    end
  end

  task automatic send(input logic [31:0] inst, input logic [127:0] ra,
                      input logic [127:0] res, input logic ill);
    exp_t e;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_ra    = ra;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        e.rt  = inst[6:0];
        e.res = res;
        e.ill = ill;
        sbq.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", 128'(sbq.size()), 128'd0);
  endtask

  initial begin
    logic [15:0] cnt0;
    logic [127:0] ra_s;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_ra     = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_result", out_result, 128'd0);
    chk("rst_out_rt", 128'(out_rt), 128'd0);
    chk("rst_out_illegal", 128'(out_illegal), 128'd0);
    chk("rst_retired", 128'(retired_cnt), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // andhi with t=0xFFFF passes ra through; also checks two-cycle latency
    send(mk(8'h15, 10'h3FF, 7'd5), RA1, RA1, 1'b0);
    in_valid = 1'b0;
    chk("lat_cycle1_idle", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle2_valid", 128'(out_valid), 128'd1);
    wait_drain();

    send(mk(8'h1D, 10'h200, 7'd6), {8{16'h0300}}, {8{16'h0100}}, 1'b0);
    send(mk(8'h0D, 10'h001, 7'd7), {8{16'h0002}}, {8{16'hFFFF}}, 1'b0);
    send(mk(8'h4D, 10'h001, 7'd8), {4{16'h0002, 16'hFFFF}}, {4{16'hFFFF, 16'h0000}}, 1'b0);
    send(mk(8'h5D, 10'h001, 7'd9), {4{16'h0002, 16'hFFFF}}, {8{16'hFFFF}}, 1'b0);
    send(mk(8'h7D, 10'h3FF, 7'd10), {4{16'h0001, 16'hFFFF}}, {4{16'h0000, 16'hFFFF}}, 1'b0);
    send(mk(8'h05, 10'h0F0, 7'd11), {8{16'h1200}}, {8{16'h12F0}}, 1'b0);
    send(mk(8'hFF, 10'h155, 7'd12), RA1, 128'd0, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Stream of 10 xorhi with the consumer stalled for cycles 3..8
    @(posedge clk);
    #1;
    cnt0      = retired_cnt;
    saw_stall = 1'b0;
    ra_s      = {8{16'hA5A5}};
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(mk(8'h45, 10'(i * 3 + 1), 7'(i + 20)), ra_s, ra_s ^ {8{16'(i * 3 + 1)}}, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    @(posedge clk);
    #1;
    chk("stream_stall_seen", 128'(saw_stall), 128'd1);
    chk("stream_retired", 128'(retired_cnt), 128'(16'(cnt0 + 16'd10)));
    chk("retired_total", 128'(retired_cnt), 128'(16'(hs_cnt)));

    // Flush with both stages full; the output handshake in the flush cycle still retires
    out_ready = 1'b0;
    send(mk(8'h05, 10'h0F0, 7'd30), {8{16'h1200}}, {8{16'h12F0}}, 1'b0);
    send(mk(8'h15, 10'h00F, 7'd31), RA1, {8{16'h000F}} & RA1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("full_in_ready", 128'(in_ready), 128'd0);
    chk("full_hold_valid", 128'(out_valid), 128'd1);
    chk("full_hold_rt", 128'(out_rt), 128'd30);
    cnt0      = retired_cnt;
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = mk(8'h1D, 10'h001, 7'd32);
    in_ra     = RA1;
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    chk("flush_retired", 128'(retired_cnt), 128'(16'(cnt0 + 16'd1)));
    repeat (4) @(posedge clk);
    #1;
    chk("flush_stays_empty", 128'(out_valid), 128'd0);

    // Asynchronous reset mid-cycle with instructions in flight
    out_ready = 1'b0;
    send(mk(8'h15, 10'h3FF, 7'd40), RA1, RA1, 1'b0);
    send(mk(8'hFF, 10'h000, 7'd41), RA1, 128'd0, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_out_result", out_result, 128'd0);
    chk("arst_out_rt", 128'(out_rt), 128'd0);
    chk("arst_out_illegal", 128'(out_illegal), 128'd0);
    chk("arst_retired", 128'(retired_cnt), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    sbq.delete();
    hs_cnt = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(mk(8'h1D, 10'h001, 7'd42), {8{16'hFFFF}}, 128'd0, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    @(posedge clk);
    #1;
    chk("post_rst_retired", 128'(retired_cnt), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
